led_flash_scheduler: RTL and testbench
======================================

// Module: led_flash_scheduler
// PURPOSE
//  Avalon-MM write master that owns the 8-bit LED PIO slave (2-bit address, chipselect, write_n, 32-bit writedata).
//  Round-robin arbitrates NUM_REQ game-event requesters; plays the granted pattern as FLASH_COUNT on/off flashes.
//  After the flashes, restores a software-set base pattern. Sits between game logic and the LED PIO; sole PIO master.
// PARAMETERS
//  NUM_REQ      4           number of requesters (2..8)
//  HOLD_CYCLES  12500000    clk cycles per on-phase and per off-phase (>=1)
//  FLASH_COUNT  3           on/off flash pairs per event (>=1)
//  CNT_W        24          hold-counter width; must hold HOLD_CYCLES-1
// PORTS
//  clk             in   1          system clock
//  reset_n         in   1          synchronous reset, active low
//  req             in   NUM_REQ    level request per requester; held until ack
//  req_pattern     in   8*NUM_REQ  LED byte per requester; requester i uses bits [8i+7:8i]
//  ack             out  NUM_REQ    one-cycle grant pulse (one-hot)
//  base_pattern    in   8          idle/restore LED value
//  base_update     in   1          one-cycle pulse: latch base_pattern
//  busy            out  1          high while a flash sequence or PIO write is in progress
//  pio_address     out  2          PIO address; always 0
//  pio_chipselect  out  1          PIO chipselect
//  pio_write_n     out  1          PIO write strobe, active low
//  pio_writedata   out  32         {24'b0, led byte}
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): state=IDLE; ack=0; busy=0; chipselect=0; write_n=1; address=0; writedata=0.
//    Base register=0, base_pending=0, RR pointer=0 (requester 0 has highest priority first).
//  - All outputs are registered. The PIO accepts every write in one cycle (no waitrequest).
//  - Each write is exactly one cycle with chipselect=1, write_n=0. Between writes: chipselect=0, write_n=1, writedata holds.
//  - base_update latches base_pattern in any state and sets base_pending. The latch itself does not affect an active sequence.
//  - FSM states: IDLE, WR_ON, HOLD_ON, WR_OFF, HOLD_OFF, WR_BASE.
//  - IDLE with base_pending=1: go to WR_BASE. This takes priority over req.
//  - IDLE with base_pending=0 and req!=0: grant the first set req at or above the RR pointer, wrapping.
//    Pulse ack[g] in this cycle, latch req_pattern[g], set RR pointer=(g+1)%NUM_REQ, flash counter=0; next state WR_ON.
//  - WR_ON: write pattern; next HOLD_ON with hold counter=0.
//  - HOLD_ON: stay HOLD_CYCLES cycles (counter 0..HOLD_CYCLES-1), then go to WR_OFF.
//  - WR_OFF: write 0x00; next HOLD_OFF.
//  - HOLD_OFF: stay HOLD_CYCLES cycles, increment flash counter on exit.
//    Exit to WR_ON if count<FLASH_COUNT, else WR_BASE.
//  - WR_BASE: write the base register value, clear base_pending, go to IDLE. Any base_update arriving in this cycle keeps base_pending set.
//  - busy=1 in every state except IDLE. Requests are not sampled outside IDLE and no ack is issued while busy.
//  - Latency: req seen in IDLE at cycle T gives ack at T and the first PIO write at T+1.
//    Full sequence: 1 + FLASH_COUNT*(2+2*HOLD_CYCLES) + 1 cycles from ack to IDLE.
//  - A req dropped before ack is simply not granted. A pattern change after ack is ignored (latched copy is used).
//  - A base_update during a sequence is written at WR_BASE. Several updates before then: the last value wins.
//  - Reset mid-sequence aborts it immediately. The PIO keeps its last value until its own reset; no restore write is issued.
// TESTING (NUM_REQ=4, HOLD_CYCLES=4, FLASH_COUNT=2)
//  1 Reset, then idle 20 cycles: no PIO writes; busy=0; ack=0; writedata=0.
//  2 base_pattern=0xA5 with base_update pulse: one write of 0x000000A5 two cycles later. busy high for 1 cycle.
//  3 req[2]=1, pattern 0x3C: ack[2] pulses; writes 3C,00,3C,00,A5 at offsets +1,+6,+11,+16,+21; IDLE at +22.
//  4 req=4'b1111 held, re-raised after each ack: grant order 0,1,2,3,0. No requester is granted twice in a row.
//  5 base_update=0x0F during HOLD_ON of flash 1, then 0xF0 during HOLD_OFF: flashes unchanged; restore writes 0xF0.
//  6 reset_n low for 1 cycle inside HOLD_ON: next cycle is IDLE; no further writes; RR pointer=0; a new req[1] is granted normally.

Source files
------------

// File: rtl/led_flash_scheduler.sv
// led_flash_scheduler
//   Sole Avalon-MM write master of the 8-bit LED PIO. Round-robin arbitrates
//   NUM_REQ game-event requesters, flashes the granted pattern FLASH_COUNT
//   times (on for HOLD_CYCLES, off for HOLD_CYCLES), then restores the
//   software-set base pattern. A base_update while idle is written at once.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   req[NUM_REQ]        level requests, held until ack
//   req_pattern         LED byte per requester, requester i at [8i+7:8i]
//   ack[NUM_REQ]        one-cycle one-hot grant pulse
//   base_pattern        restore/idle LED value, latched on base_update
//   base_update         one-cycle latch strobe
//   busy                high while a sequence or PIO write is in progress
//   pio_*               Avalon-MM write port to the LED PIO (address fixed 0)
module led_flash_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 12500000,
    parameter int FLASH_COUNT = 3,
    parameter int CNT_W       = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_pattern,
    output logic [NUM_REQ-1:0]     ack,
    input  logic [7:0]             base_pattern,
    input  logic                   base_update,
    output logic                   busy,
    output logic [1:0]             pio_address,
    output logic                   pio_chipselect,
    output logic                   pio_write_n,
    output logic [31:0]            pio_writedata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int FC_W  = $clog2(FLASH_COUNT + 1);

    typedef enum logic [2:0] {IDLE, WR_ON, HOLD_ON, WR_OFF, HOLD_OFF, WR_BASE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   hold_cnt;
    logic [FC_W-1:0]    flash_cnt;
    logic [7:0]         pattern;
    logic [7:0]         base_reg;
    logic               base_pending;
    logic [PTR_W-1:0]   rr_ptr;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic               hold_done;
    logic               last_flash;

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_vld && req[(int'(rr_ptr) + off) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
            end
        end
    end

    assign hold_done  = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign last_flash = (flash_cnt == FC_W'(FLASH_COUNT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                // A pending restore beats new requests.
                if (base_pending)   state_nx = WR_BASE;
                else if (grant_vld) state_nx = WR_ON;
            end
            WR_ON:    state_nx = HOLD_ON;
            HOLD_ON:  if (hold_done) state_nx = WR_OFF;
            WR_OFF:   state_nx = HOLD_OFF;
            HOLD_OFF: if (hold_done) state_nx = last_flash ? WR_BASE : WR_ON;
            WR_BASE:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs. The PIO strobe is driven from the
    // current WR_* state, so each write lands one cycle after the state
    // that issues it; busy follows the same one-cycle offset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack            <= '0;
            busy           <= 1'b0;
            pio_address    <= 2'b00;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            hold_cnt       <= '0;
            flash_cnt      <= '0;
            pattern        <= '0;
            base_reg       <= '0;
            base_pending   <= 1'b0;
            rr_ptr         <= '0;
        end else begin
            ack            <= '0;
            busy           <= (state != IDLE);
            pio_address    <= 2'b00;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;

            if (base_update) base_reg <= base_pattern;
            // A new update in the WR_BASE cycle keeps pending set for another restore.
            if (base_update)             base_pending <= 1'b1;
            else if (state == WR_BASE)   base_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (!base_pending && grant_vld) begin
                        ack       <= NUM_REQ'(1) << grant_idx;
                        pattern   <= req_pattern[8*int'(grant_idx) +: 8];
                        rr_ptr    <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
                        flash_cnt <= '0;
                    end
                end
                WR_ON: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= {24'b0, pattern};
                    hold_cnt       <= '0;
                end
                HOLD_ON: hold_cnt <= hold_cnt + CNT_W'(1);
                WR_OFF: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= 32'h0;
                    hold_cnt       <= '0;
                end
                HOLD_OFF: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (hold_done) flash_cnt <= flash_cnt + FC_W'(1);
                end
                WR_BASE: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_writedata  <= {24'b0, base_reg};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_flash_scheduler.sv
// Testbench for led_flash_scheduler (NUM_REQ=4, HOLD_CYCLES=4, FLASH_COUNT=2).
// Stimulus pushes expected acks / PIO writes (value + cycle) into queues;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_led_flash_scheduler;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_pattern = '0;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           base_pattern = '0;
    logic                 base_update = 1'b0;
    logic                 busy;
    logic [1:0]           pio_address;
    logic                 pio_chipselect;
    logic                 pio_write_n;
    logic [31:0]          pio_writedata;

    led_flash_scheduler #(
        .NUM_REQ(4), .HOLD_CYCLES(4), .FLASH_COUNT(2), .CNT_W(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_pattern(req_pattern),
        .ack(ack), .base_pattern(base_pattern), .base_update(base_update),
        .busy(busy), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t wr_q[$];
    exp_t ack_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected ack at T, writes at T+1,+6,+11,+16 (pattern/0 twice) and base at T+21.
    task automatic push_seq(input int t, input logic [7:0] pat, input logic [7:0] base,
                            input logic [3:0] ackv);
        exp_t e;
        e.val = {28'b0, ackv}; e.cyc = t;      ack_q.push_back(e);
        e.val = {24'b0, pat};  e.cyc = t + 1;  wr_q.push_back(e);
        e.val = 32'h0;         e.cyc = t + 6;  wr_q.push_back(e);
        e.val = {24'b0, pat};  e.cyc = t + 11; wr_q.push_back(e);
        e.val = 32'h0;         e.cyc = t + 16; wr_q.push_back(e);
        e.val = {24'b0, base}; e.cyc = t + 21; wr_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (ack != '0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", {28'b0, ack}, 32'h0);
            else begin
                e = ack_q.pop_front();
                chk("ack_value", {28'b0, ack}, e.val);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
            chk("wr_address", {30'b0, pio_address}, 32'h0);
            if (wr_q.size() == 0) chk("wr_unexpected", pio_writedata, 32'hFFFF_FFFF);
            else begin
                e = wr_q.pop_front();
                chk("wr_data", pio_writedata, e.val);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t;
        exp_t e;

        // 1: reset and idle
        tick(3);
        chk("rst_ack", {28'b0, ack}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_cs", {31'b0, pio_chipselect}, 32'h0);
        chk("rst_wn", {31'b0, pio_write_n}, 32'h1);
        chk("rst_addr", {30'b0, pio_address}, 32'h0);
        chk("rst_wd", pio_writedata, 32'h0);
        reset_n = 1'b1;
        tick(20);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("idle_wd", pio_writedata, 32'h0);
        chk("idle_ack", {28'b0, ack}, 32'h0);

        // 2: base update while idle
        c = cyc;
        base_pattern = 8'hA5; base_update = 1'b1;
        e.val = 32'h0000_00A5; e.cyc = c + 3; wr_q.push_back(e);
        tick(1); base_update = 1'b0;
        chk("base_busy_c1", {31'b0, busy}, 32'h0);
        tick(1); chk("base_busy_c2", {31'b0, busy}, 32'h0);
        tick(1); chk("base_busy_c3", {31'b0, busy}, 32'h1);
        tick(1); chk("base_busy_c4", {31'b0, busy}, 32'h0);
        tick(3);

        // 3: single request, pattern 0x3C
        c = cyc; t = c + 1;
        req = 4'b0100; req_pattern = 32'h003C_0000;
        push_seq(t, 8'h3C, 8'hA5, 4'b0100);
        tick(1); req = '0; req_pattern = 32'hFFFF_FFFF; // post-ack change is ignored
        chk("seq_busy_ack", {31'b0, busy}, 32'h0);
        tick(21); chk("seq_busy_last", {31'b0, busy}, 32'h1);
        tick(1);  chk("seq_busy_idle", {31'b0, busy}, 32'h0);
        tick(3);

        // 4: round robin from a fresh pointer (reset clears base to 0)
        reset_n = 1'b0; tick(1); reset_n = 1'b1; tick(2);
        c = cyc; t = c + 1;
        req = 4'b1111; req_pattern = 32'h8844_2211;
        for (int k = 0; k < 5; k++)
            push_seq(t + 22*k, 8'h11 << (k % 4), 8'h00, 4'b0001 << (k % 4));
        tick(89); req = '0;
        tick(25);

        // 5: base updates during a sequence, last one wins
        c = cyc; t = c + 1;
        req = 4'b0010; req_pattern = 32'h0000_5A00;
        push_seq(t, 8'h5A, 8'hF0, 4'b0010);
        tick(1); req = '0;
        tick(1); base_pattern = 8'h0F; base_update = 1'b1;
        tick(1); base_update = 1'b0;
        tick(4); base_pattern = 8'hF0; base_update = 1'b1;
        tick(1); base_update = 1'b0;
        tick(25);

        // 6: reset during HOLD_ON
        c = cyc; t = c + 1;
        req = 4'b0100; req_pattern = 32'h0077_0000;
        e.val = 32'h4;  e.cyc = t;     ack_q.push_back(e);
        e.val = 32'h77; e.cyc = t + 1; wr_q.push_back(e);
        tick(1); req = '0;
        tick(2); reset_n = 1'b0;
        tick(1); reset_n = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_cs", {31'b0, pio_chipselect}, 32'h0);
        chk("abort_wn", {31'b0, pio_write_n}, 32'h1);
        chk("abort_wd", pio_writedata, 32'h0);
        tick(10);
        // pointer back at 0: 1010 grants requester 1, not 3
        c = cyc; t = c + 1;
        req = 4'b1010; req_pattern = 32'h9900_6600;
        push_seq(t, 8'h66, 8'h00, 4'b0010);
        tick(1); req = '0;
        tick(26);

        chk("wr_q_drained", wr_q.size(), 32'h0);
        chk("ack_q_drained", ack_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
